// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction-fetch controller that sits right after the program-counter
// register. It accepts a PC, runs a req/ack read against instruction memory and
// returns the 32-bit instruction with a valid flag. While a fetch is in flight
// or a result is waiting to be taken, it holds the PC register through
// pc_stall. A misaligned PC or a memory that never acks gives an error result
// (fetch_err=1, instr_out=0).
//
// Optional feature (macro IFETCH_REUSE_EN):
//   When the macro is defined, a one-entry tag remembers the last successfully
//   fetched address and instruction. An aligned PC that matches a valid tag
//   goes straight to DONE and issues no memory request. When the macro is not
//   defined, every accepted PC goes to memory and no tag storage exists.
//
// Parameters:
//   TIMEOUT   cycles mem_req may stay high without mem_ack (1..2^TMO_W-1)
//   TMO_W     width of the timeout counter
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   pc_in        in   PC value from the PC register
//   pc_valid     in   pc_in should be fetched
//   consume      in   downstream takes the presented instruction or error
//   mem_ack      in   mem_rdata is valid this cycle
//   mem_rdata    in   instruction memory read data
//   mem_req      out  read request to instruction memory
//   mem_addr     out  word-aligned read byte address
//   instr_out    out  fetched instruction (0 on error)
//   instr_valid  out  result valid, held until consume
//   fetch_err    out  result is an error (misaligned or timeout)
//   pc_stall     out  PC register must hold
//   state_dbg    out  current FSM state, for observation only
//
// Handshake: a result is transferred on every rising edge where
// instr_valid=1 and consume=1. The memory read completes on the first rising
// edge where mem_req=1 and mem_ack=1; mem_req and mem_addr stay stable until
// then. A PC is taken on a rising edge where pc_valid=1 and the controller is
// either idle or handing over a good instruction that is consumed in the same
// cycle.
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int TMO_W   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  input  logic        consume,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic        pc_stall,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Counter value seen in the last REQ cycle that may still be acked.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        instr_q, instr_d;
  logic               accept;
  logic               hit;
  logic [31:0]        hit_instr;

`ifdef IFETCH_REUSE_EN
  logic [31:0] last_addr_q;
  logic [31:0] last_instr_q;
  logic        last_ok_q;

  assign hit       = last_ok_q && (pc_in == last_addr_q);
  assign hit_instr = last_instr_q;

  // The tag is refreshed on every successful memory read and cleared on any
  // transition into ERR, so a later error never leaves a stale entry usable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_addr_q  <= '0;
      last_instr_q <= '0;
      last_ok_q    <= 1'b0;
    end else begin
      if (state_q == ST_REQ && mem_ack) begin
        last_addr_q  <= addr_q;
        last_instr_q <= mem_rdata;
        last_ok_q    <= 1'b1;
      end else if (state_d == ST_ERR && state_q != ST_ERR) begin
        last_ok_q <= 1'b0;
      end
    end
  end
`else
  assign hit       = 1'b0;
  assign hit_instr = '0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    accept  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        accept = pc_valid;
      end
      ST_REQ: begin
        // An ack always wins, including in the last allowed cycle.
        if (mem_ack) begin
          instr_d = mem_rdata;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == TMO_LAST) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_DONE: begin
        if (consume) begin
          // Back-to-back: a new PC is taken in the same cycle the result
          // leaves, so no idle cycle appears between fetches.
          if (pc_valid) begin
            accept = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ERR: begin
        if (consume) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      addr_d = pc_in;
      cnt_d  = '0;
      if (pc_in[1:0] != 2'b00) begin
        state_d = ST_ERR;
      end else if (hit) begin
        instr_d = hit_instr;
        state_d = ST_DONE;
      end else begin
        state_d = ST_REQ;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. All are decoded from registered state (plus consume for the
  // stall), so an asynchronous reset clears them without waiting for a clock.
  // ---------------------------------------------------------------------------
  assign mem_req     = (state_q == ST_REQ);
  assign mem_addr    = addr_q & 32'hFFFF_FFFC;
  assign instr_valid = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign fetch_err   = (state_q == ST_ERR);
  assign instr_out   = (state_q == ST_ERR) ? 32'h0000_0000 : instr_q;
  assign pc_stall    = (state_q == ST_REQ) || (instr_valid && !consume);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Bench for imem_fetch_ctrl. A driver presents PCs, a memory responder answers
// requests with a chosen latency, and a reference model pushes the expected
// result of each accepted PC ({err, instr, number of mem_req cycles}) into a
// queue. A monitor pops that queue whenever a result is consumed.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

  localparam int TIMEOUT = 15;
  localparam int TMO_W   = 8;
  localparam int NEVER   = 99;
`ifdef IFETCH_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk       = 1'b0;
  logic        reset_n   = 1'b1;
  logic [31:0] pc_in     = '0;
  logic        pc_valid  = 1'b0;
  logic        consume   = 1'b0;
  logic        mem_ack   = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        fetch_err;
  logic        pc_stall;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .consume     (consume),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .pc_stall    (pc_stall),
    .state_dbg   (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Shared bench state
  // ---------------------------------------------------------------------------
  int          n_chk = 0;
  int          n_fail = 0;
  logic [40:0] exp_q[$];          // {err, instr[31:0], mem_req cycles[7:0]}
  logic [31:0] mem_img [0:127];
  int          cur_lat = NEVER;
  int          cons_pct = 100;
  bit          junk_ack_force = 1'b0;
  int          reqc = 0;
  int          idle_cnt = 0;
  logic [1:0]  idle_code = '0;
  logic [31:0] m_last_addr = '0;
  bit          m_last_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: result of one accepted PC given the memory latency chosen
  // for it (lat = REQ cycle in which the ack comes; > TIMEOUT means never).
  // ---------------------------------------------------------------------------
  function automatic void model_accept(input logic [31:0] pc, input int lat);
    logic [40:0] e;
    if (pc[1:0] != 2'b00) begin
      e = {1'b1, 32'h0, 8'd0};
      m_last_ok = 1'b0;
    end else if (REUSE && m_last_ok && pc == m_last_addr) begin
      e = {1'b0, mem_img[pc[8:2]], 8'd0};
    end else if (lat > TIMEOUT) begin
      e = {1'b1, 32'h0, 8'(TIMEOUT)};
      m_last_ok = 1'b0;
    end else begin
      e = {1'b0, mem_img[pc[8:2]], 8'(lat)};
      m_last_ok   = 1'b1;
      m_last_addr = pc;
    end
    exp_q.push_back(e);
  endfunction

  // ---------------------------------------------------------------------------
  // Memory responder and consumer (drive on the falling edge)
  // ---------------------------------------------------------------------------
  int mem_cnt = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      mem_cnt++;
      mem_ack   = (mem_cnt == cur_lat);
      mem_rdata = mem_ack ? mem_img[mem_addr[8:2]] : $urandom();
    end else begin
      mem_cnt   = 0;
      mem_ack   = junk_ack_force || ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom();
    end
  end

  always @(negedge clk) begin
    consume = ($urandom_range(0, 99) < cons_pct);
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard (samples 2 time units after the falling edge)
  // ---------------------------------------------------------------------------
  logic        prev_hold = 1'b0;
  logic [31:0] prev_instr = '0;
  logic        prev_err = 1'b0;
  logic [40:0] e_pop;
  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      chk("pc_stall", pc_stall, mem_req || (instr_valid && !consume));
      chk("state_dbg_idle", (state_dbg == idle_code), (!instr_valid && !pc_stall));
      if (mem_req) begin
        reqc++;
        chk("req_no_valid", instr_valid, 1'b0);
      end
      if (!instr_valid && !pc_stall) idle_cnt++;
      if (prev_hold) begin
        chk("hold_valid", instr_valid, 1'b1);
        chk("hold_instr", instr_out, prev_instr);
        chk("hold_err", fetch_err, prev_err);
      end
      prev_hold  = instr_valid && !consume;
      prev_instr = instr_out;
      prev_err   = fetch_err;
      if (instr_valid && consume) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          e_pop = exp_q.pop_front();
          chk("result_err", fetch_err, e_pop[40]);
          chk("result_instr", instr_out, e_pop[39:8]);
          chk("result_req_cycles", reqc, e_pop[7:0]);
        end
        reqc = 0;
      end
    end else begin
      prev_hold = 1'b0;
      reqc      = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Present pc until accepted, then return 1 time unit after the accepting edge.
  task automatic fetch(input logic [31:0] pc, input int lat);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    @(negedge clk);
    pc_in    = pc;
    pc_valid = 1'b1;
    while (!acc && n < 200) begin
      #1;
      acc = (!instr_valid && !pc_stall) || (instr_valid && !fetch_err && consume);
      if (acc) begin
        model_accept(pc, lat);
        cur_lat = lat;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!acc) fail_now("fetch_accept_timeout");
    @(posedge clk);
    #1;
    pc_valid = 1'b0;
    pc_in    = $urandom();
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!instr_valid && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!instr_valid) fail_now("wait_valid_timeout");
  endtask

  task automatic drain();
    int n;
    n = 0;
    cons_pct = 100;
    @(negedge clk);
    #3;
    while (!(exp_q.size() == 0 && !instr_valid && !pc_stall) && n < 1000) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 1000) fail_now("drain_timeout");
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 128; i++) mem_img[i] = $urandom();
    mem_img[32'h100 >> 2] = 32'h2008_000A;
    mem_img[32'h010 >> 2] = 32'h8C09_0004;

    // Reset values
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_fetch_err", fetch_err, 1'b0);
    chk("rst_pc_stall", pc_stall, 1'b0);
    idle_code = state_dbg;
    repeat (2) @(negedge clk);
    #3 reset_n = 1'b1;

    // Reset asserted while a request is outstanding
    cons_pct = 100;
    fetch(32'h40, NEVER);
    chk("midrst_req_before", mem_req, 1'b1);
    chk("midrst_addr_before", mem_addr, 32'h40);
    repeat (3) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 1'b0);
    chk("midrst_instr_valid", instr_valid, 1'b0);
    chk("midrst_pc_stall", pc_stall, 1'b0);
    exp_q.delete();
    m_last_ok = 1'b0;
    cur_lat   = NEVER;
    junk_ack_force = 1'b1;
    repeat (2) @(negedge clk);
    #3 reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #3;
      chk("postrst_instr_valid", instr_valid, 1'b0);
      chk("postrst_mem_req", mem_req, 1'b0);
      chk("postrst_pc_stall", pc_stall, 1'b0);
    end
    junk_ack_force = 1'b0;

    // Normal fetch, ack in the third REQ cycle, result held until consumed
    cons_pct = 0;
    fetch(32'h100, 3);
    chk("f100_mem_req", mem_req, 1'b1);
    chk("f100_mem_addr", mem_addr, 32'h100);
    chk("f100_not_valid", instr_valid, 1'b0);
    wait_valid(20);
    chk("f100_instr", instr_out, 32'h2008_000A);
    chk("f100_err", fetch_err, 1'b0);
    repeat (3) @(negedge clk);
    #3;
    chk("f100_stall_hold", pc_stall, 1'b1);
    chk("f100_valid_hold", instr_valid, 1'b1);
    drain();

    // Misaligned PC
    cons_pct = 0;
    fetch(32'h102, 1);
    chk("mis_mem_req", mem_req, 1'b0);
    chk("mis_valid", instr_valid, 1'b1);
    chk("mis_err", fetch_err, 1'b1);
    chk("mis_instr", instr_out, 32'h0);
    drain();
    chk("mis_cleared", instr_valid, 1'b0);

    // Timeout: memory never acks
    cons_pct = 0;
    fetch(32'h200, NEVER);
    wait_valid(40);
    chk("tmo_err", fetch_err, 1'b1);
    chk("tmo_mem_req", mem_req, 1'b0);
    drain();

    // Ack in the very last allowed cycle still succeeds
    fetch(32'h0C, TIMEOUT);
    drain();

    // Back-to-back zero-wait fetches
    cons_pct = 100;
    fetch(32'h0, 1);
    chk("b2b_req0", mem_req, 1'b1);
    idle_cnt = 0;
    fetch(32'h4, 1);
    fetch(32'h8, 1);
    @(posedge clk);
    #1;
    chk("zero_wait_valid", instr_valid, 1'b1);
    chk("b2b_no_idle", idle_cnt, 0);
    drain();

    // Repeat fetch of the same address, then after an error
    cons_pct = 100;
    fetch(32'h10, 2);
    drain();
    fetch(32'h10, 2);
    chk("repeat_mem_req", mem_req, REUSE ? 1'b0 : 1'b1);
    chk("repeat_valid", instr_valid, REUSE ? 1'b1 : 1'b0);
    drain();
    fetch(32'h12, 1);
    drain();
    fetch(32'h10, 2);
    chk("after_err_mem_req", mem_req, 1'b1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      int lat;
      logic [31:0] pc;
      if (i % 25 == 0) cons_pct = $urandom_range(20, 100);
      r = $urandom_range(0, 9);
      if (r < 6)       lat = $urandom_range(1, 4);
      else if (r < 8)  lat = $urandom_range(5, TIMEOUT);
      else if (r == 8) lat = TIMEOUT;
      else             lat = NEVER;
      pc = 32'($urandom_range(0, 31)) << 2;
      if ($urandom_range(0, 9) == 0) pc = pc | 32'($urandom_range(1, 3));
      fetch(pc, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
